// File: rtl/dcache_snoop_responder.sv
// rtl/dcache_snoop_responder.sv - L1 snoop responder for the MSI bus: hit detect, M-block supply, state downgrade/invalidate.
// Optional SNOOP_STATS_EN adds saturating hit/supply counters on snp_hits/snp_supplies.
module dcache_snoop_responder #(
  parameter int SETS = 8,
  parameter int TAGW = 26,
  parameter int IDXW = $clog2(SETS)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ccwait,
  input  logic            ccinv,
  input  logic [31:0]     ccsnoopaddr,
  input  logic            dwait,
  output logic [IDXW-1:0] lk_idx,
  input  logic [TAGW-1:0] lk_tag0,
  input  logic [TAGW-1:0] lk_tag1,
  input  logic [1:0]      lk_st0,
  input  logic [1:0]      lk_st1,
  input  logic [63:0]     lk_data0,
  input  logic [63:0]     lk_data1,
  output logic            ccwrite,
  output logic            sup_valid,
  output logic [31:0]     ccdstore,
  output logic [31:0]     ccdaddr,
  output logic            snoop_hold,
  output logic            st_wen,
  output logic            st_way,
  output logic [IDXW-1:0] st_idx,
  output logic [1:0]      st_next,
  output logic [15:0]     snp_hits,
  output logic [15:0]     snp_supplies
);

  typedef enum logic [2:0] {IDLE, SUPPLY0, SUPPLY1, UPDATE, DONE} state_t;
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  state_t          state, state_n;
  logic [TAGW-1:0] tag_q;
  logic [IDXW-1:0] idx_q;
  logic            way_q;
  logic [63:0]     data_q;
  logic            inv_l;

  // Gating the request with reset keeps every output quiet while nRST is low.
  logic            snoop_req;
  logic [TAGW-1:0] snp_tag;
  logic [IDXW-1:0] snp_idx;
  logic            hit0, hit1, hit, hit_way;
  logic [1:0]      hit_st;
  logic [63:0]     hit_data;
  logic            unused_addr_bits;

  assign snoop_req        = ccwait & nRST;
  assign snp_tag          = ccsnoopaddr[31:3+IDXW];
  assign snp_idx          = ccsnoopaddr[3+IDXW-1:3];
  assign unused_addr_bits = ^ccsnoopaddr[2:0];

  assign hit0     = (lk_st0 != ST_I) && (lk_tag0 == snp_tag);
  assign hit1     = (lk_st1 != ST_I) && (lk_tag1 == snp_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_st   = hit0 ? lk_st0 : lk_st1;
  assign hit_data = hit0 ? lk_data0 : lk_data1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      tag_q  <= '0;
      idx_q  <= '0;
      way_q  <= 1'b0;
      data_q <= '0;
      inv_l  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && snoop_req) begin
        tag_q  <= snp_tag;
        idx_q  <= snp_idx;
        way_q  <= hit_way;
        data_q <= hit_data;
        inv_l  <= ccinv;
      end else if ((state == SUPPLY0 || state == SUPPLY1) && ccwait) begin
        inv_l <= inv_l | ccinv;
      end
    end
  end

  always_comb begin
    state_n    = state;
    lk_idx     = idx_q;
    ccwrite    = 1'b0;
    sup_valid  = 1'b0;
    ccdstore   = '0;
    ccdaddr    = '0;
    snoop_hold = 1'b1;
    st_wen     = 1'b0;
    st_way     = 1'b0;
    st_idx     = '0;
    st_next    = ST_I;
    case (state)
      IDLE: begin
        lk_idx     = nRST ? snp_idx : '0;
        snoop_hold = snoop_req;
        if (snoop_req) begin
          ccwrite = hit && (hit_st == ST_M);
          if (hit && hit_st == ST_M)
            state_n = SUPPLY0;
          else if (hit && hit_st == ST_S && ccinv)
            state_n = UPDATE;
          else
            state_n = DONE;
        end
      end
      SUPPLY0: begin
        ccwrite   = 1'b1;
        sup_valid = 1'b1;
        ccdstore  = data_q[31:0];
        ccdaddr   = {tag_q, idx_q, 3'b000};
        if (!ccwait)     state_n = IDLE;
        else if (!dwait) state_n = SUPPLY1;
      end
      SUPPLY1: begin
        ccwrite   = 1'b1;
        sup_valid = 1'b1;
        ccdstore  = data_q[63:32];
        ccdaddr   = {tag_q, idx_q, 3'b100};
        if (!ccwait)     state_n = IDLE;
        else if (!dwait) state_n = UPDATE;
      end
      UPDATE: begin
        // A supplied M line never stays M: it drops to S, or to I on invalidate.
        st_wen  = 1'b1;
        st_way  = way_q;
        st_idx  = idx_q;
        st_next = inv_l ? ST_I : ST_S;
        state_n = DONE;
      end
      DONE: begin
        if (!ccwait) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snp_hits     <= '0;
      snp_supplies <= '0;
    end else begin
      if (state == IDLE && snoop_req && hit && snp_hits != 16'hFFFF)
        snp_hits <= snp_hits + 16'd1;
      if (state == SUPPLY1 && ccwait && !dwait && snp_supplies != 16'hFFFF)
        snp_supplies <= snp_supplies + 16'd1;
    end
  end
`else
  assign snp_hits     = '0;
  assign snp_supplies = '0;
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb/tb_dcache_snoop_responder.sv - scoreboard bench: directed snoops, monitor pops expected supply words and state writes.
module tb_dcache_snoop_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ccwait, ccinv, dwait;
  logic [31:0] ccsnoopaddr;
  logic [2:0]  lk_idx;
  logic [25:0] lk_tag0, lk_tag1;
  logic [1:0]  lk_st0, lk_st1;
  logic [63:0] lk_data0, lk_data1;
  logic        ccwrite, sup_valid, snoop_hold, st_wen, st_way;
  logic [31:0] ccdstore, ccdaddr;
  logic [2:0]  st_idx;
  logic [1:0]  st_next;
  logic [15:0] snp_hits, snp_supplies;

  logic [25:0] tag_a  [2][8];
  logic [1:0]  st_a   [2][8];
  logic [63:0] data_a [2][8];

  logic [63:0] sup_q[$];
  logic [5:0]  wr_q[$];
  logic [63:0] e_sup;
  logic [5:0]  e_wr;
  int n_checks = 0;
  int n_fail   = 0;

  dcache_snoop_responder dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .lk_idx(lk_idx), .lk_tag0(lk_tag0), .lk_tag1(lk_tag1),
    .lk_st0(lk_st0), .lk_st1(lk_st1), .lk_data0(lk_data0), .lk_data1(lk_data1),
    .ccwrite(ccwrite), .sup_valid(sup_valid), .ccdstore(ccdstore), .ccdaddr(ccdaddr),
    .snoop_hold(snoop_hold), .st_wen(st_wen), .st_way(st_way), .st_idx(st_idx),
    .st_next(st_next), .snp_hits(snp_hits), .snp_supplies(snp_supplies)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    lk_tag0  = tag_a[0][lk_idx];
    lk_tag1  = tag_a[1][lk_idx];
    lk_st0   = st_a[0][lk_idx];
    lk_st1   = st_a[1][lk_idx];
    lk_data0 = data_a[0][lk_idx];
    lk_data1 = data_a[1][lk_idx];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (sup_valid && !dwait) begin
      if (sup_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_supply: got %0h@%0h expected none", ccdstore, ccdaddr);
      end else begin
        e_sup = sup_q.pop_front();
        check("supply_word", {ccdaddr, ccdstore}, e_sup);
      end
    end
    if (st_wen) begin
      if (wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_st_wen: got way %0d idx %0d next %0d expected none", st_way, st_idx, st_next);
      end else begin
        e_wr = wr_q.pop_front();
        check("state_write", {st_way, st_idx, st_next}, e_wr);
      end
    end
  end

  // Full M-hit snoop with no stalls and no invalidate.
  task automatic snoop_m(input logic [31:0] addr, input logic way, input logic [2:0] idx,
                         input logic [31:0] w0, input logic [31:0] w1);
    sup_q.push_back({addr, w0});
    sup_q.push_back({addr | 32'h4, w1});
    wr_q.push_back({way, idx, 2'b01});
    ccsnoopaddr = addr; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
    #1;
    check("m_ccwrite_same_cycle", ccwrite, 1);
    check("m_lk_idx", lk_idx, idx);
    tick(); #1;
    check("m_sup0_valid", sup_valid, 1);
    tick(); #1;
    check("m_sup1_addr", ccdaddr, addr | 32'h4);
    check("m_sup1_ccwrite", ccwrite, 1);
    tick(); #1;
    check("m_update_ccwrite", ccwrite, 0);
    check("m_update_st_wen", st_wen, 1);
    tick(); #1;
    check("m_done_hold", snoop_hold, 1);
    check("m_done_st_wen", st_wen, 0);
    ccwait = 1'b0;
    tick(); #1;
    check("m_idle_hold", snoop_hold, 0);
  endtask

  // S hit (or miss) without invalidate: straight to DONE, nothing supplied or written.
  task automatic snoop_quiet(input logic [31:0] addr, input string tag);
    ccsnoopaddr = addr; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check({tag, "_ccwrite"}, ccwrite, 0);
      check({tag, "_hold"}, snoop_hold, 1);
      check({tag, "_sup_valid"}, sup_valid, 0);
      tick();
    end
    ccwait = 1'b0;
    tick(); #1;
    check({tag, "_idle_hold"}, snoop_hold, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        tag_a[w][s] = '0; st_a[w][s] = 2'b00; data_a[w][s] = '0;
      end
    tag_a[0][1] = 26'h99;  st_a[0][1] = 2'b01;
    tag_a[1][1] = 26'h41;  st_a[1][1] = 2'b10; data_a[1][1] = {32'hBEEF0002, 32'hBEEF0001};
    tag_a[0][5] = 26'h123; st_a[0][5] = 2'b10; data_a[0][5] = {32'hCAFE0002, 32'hCAFE0001};
    tag_a[1][5] = 26'h123; st_a[1][5] = 2'b01; data_a[1][5] = {32'hDEAD0002, 32'hDEAD0001};
    tag_a[0][2] = 26'h7;   st_a[0][2] = 2'b01;

    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccsnoopaddr = '0;
    tick(); tick();
    check("rst_ccwrite", ccwrite, 0);
    check("rst_sup_valid", sup_valid, 0);
    check("rst_hold", snoop_hold, 0);
    check("rst_st_wen", st_wen, 0);
    check("rst_hits", snp_hits, 0);
    nRST = 1'b1;
    tick();

    snoop_quiet(32'h0000_2048, "miss");
    snoop_quiet(32'h0000_01D0, "s_noinv");
    snoop_m(32'h0000_1048, 1'b1, 3'd1, 32'hBEEF0001, 32'hBEEF0002);

    // M hit on both ways (way0 wins), 3 stall cycles per word, ccinv in 2nd supply cycle.
    sup_q.push_back({32'h0000_48E8, 32'hCAFE0001});
    sup_q.push_back({32'h0000_48EC, 32'hCAFE0002});
    wr_q.push_back({1'b0, 3'd5, 2'b00});
    ccsnoopaddr = 32'h0000_48E8; ccinv = 1'b0; dwait = 1'b1; ccwait = 1'b1;
    #1;
    check("inv_ccwrite_same_cycle", ccwrite, 1);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4; i++) begin
        tick();
        dwait = (i < 3);
        ccinv = (w == 0 && i == 1);
        #1;
        check("inv_sup_valid", sup_valid, 1);
        check("inv_held_word", ccdstore, (w == 0) ? 32'hCAFE0001 : 32'hCAFE0002);
        check("inv_held_addr", ccdaddr, (w == 0) ? 32'h0000_48E8 : 32'h0000_48EC);
      end
    tick(); ccinv = 1'b0; #1;
    check("inv_st_wen", st_wen, 1);
    check("inv_st_next", st_next, 0);
    tick(); ccwait = 1'b0;
    tick();

    // S hit with invalidate: no supply, state write next cycle.
    wr_q.push_back({1'b0, 3'd2, 2'b00});
    ccsnoopaddr = 32'h0000_01D0; ccinv = 1'b1; dwait = 1'b0; ccwait = 1'b1;
    #1;
    check("sinv_ccwrite", ccwrite, 0);
    tick(); #1;
    check("sinv_st_wen", st_wen, 1);
    check("sinv_sup_valid", sup_valid, 0);
    check("sinv_ccdstore", ccdstore, 0);
    tick(); ccwait = 1'b0; ccinv = 1'b0;
    tick();

    // Abort during SUPPLY1.
    sup_q.push_back({32'h0000_1048, 32'hBEEF0001});
    ccsnoopaddr = 32'h0000_1048; dwait = 1'b0; ccwait = 1'b1;
    tick();
    tick(); ccwait = 1'b0; dwait = 1'b1; #1;
    check("abort_still_valid", sup_valid, 1);
    tick(); #1;
    check("abort_sup_valid", sup_valid, 0);
    check("abort_hold", snoop_hold, 0);
    check("abort_ccdaddr", ccdaddr, 0);
    tick(); tick();

    // Reset pulled in SUPPLY0.
    ccsnoopaddr = 32'h0000_1048; dwait = 1'b1; ccwait = 1'b1;
    tick(); #1;
    check("rstmid_pre_valid", sup_valid, 1);
    nRST = 1'b0; #1;
    check("rstmid_ccwrite", ccwrite, 0);
    check("rstmid_sup_valid", sup_valid, 0);
    check("rstmid_hold", snoop_hold, 0);
    check("rstmid_ccdstore", ccdstore, 0);
    check("rstmid_st_wen", st_wen, 0);
    ccwait = 1'b0;
    tick(); nRST = 1'b1;
    tick(); #1;
    check("rstmid_after_hold", snoop_hold, 0);
    check("rstmid_hits_clear", snp_hits, 0);

    snoop_m(32'h0000_1048, 1'b1, 3'd1, 32'hBEEF0001, 32'hBEEF0002);
    snoop_m(32'h0000_1048, 1'b1, 3'd1, 32'hBEEF0001, 32'hBEEF0002);
    snoop_quiet(32'h0000_01D0, "stats_s");
`ifdef SNOOP_STATS_EN
    check("stats_hits", snp_hits, 3);
    check("stats_supplies", snp_supplies, 2);
`else
    check("stats_hits_off", snp_hits, 0);
    check("stats_supplies_off", snp_supplies, 0);
`endif

    tick(); tick();
    check("sup_q_drained", sup_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
